regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two producers: the in-order ALU writeback stream from the EX/WB pipeline register, and a multi-cycle unit (load/multiply) with a valid/ready handshake.
- ALU writes are buffered in a small FIFO.
- Arbitration uses ALU priority with a starvation override for the multi-cycle unit.
- Exports a pending-write mask and a stall request for the hazard unit.

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. In-order ALU writebacks are buffered in a
// small FIFO and merged with a valid/ready multi-cycle result stream. The ALU
// side has priority, with a starvation override for the multi-cycle unit.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STALL_THRESH = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wr_en,
  input  logic [4:0]  alu_wr_addr,
  input  logic [31:0] alu_wr_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_addr,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [31:0] pend_mask,
  output logic        stall_req,
  output logic        overflow_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - STALL_THRESH);
  localparam logic [SW-1:0] STARVE_C  = SW'(STARVE_LIMIT);

  logic [4:0]            fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt;

  logic fifo_empty, fifo_full, mc_hit, mc_zero, mc_blocked;
  logic grant_mc, grant_fifo, push_req, push;

  // Arbitration: per-slot valid bits make the hazard match independent of
  // pointer arithmetic. An x0 multi-cycle result is always accepted.
  always_comb begin
    mc_hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[AW'(i)] && (fifo_addr[AW'(i)] == mc_addr)) mc_hit = 1'b1;
    end
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    mc_zero    = mc_valid && (mc_addr == 5'd0);
    mc_blocked = mc_valid && mc_hit;
    grant_mc   = !rst && mc_valid && !mc_blocked &&
                 (fifo_empty || mc_zero || (starve_cnt >= STARVE_C));
    grant_fifo = !rst && !fifo_empty && !grant_mc;
    push_req   = alu_wr_en && (alu_wr_addr != 5'd0);
    push       = push_req && (!fifo_full || grant_fifo);
  end

  // FIFO control: pointers, occupancy, slot valid bits, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_vld     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (grant_fifo) rd_ptr <= rd_ptr + AW'(1);
      if (grant_fifo) fifo_vld[rd_ptr] <= 1'b0;
      if (push) fifo_vld[wr_ptr] <= 1'b1;
      case ({push, grant_fifo})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !push) overflow_err <= 1'b1;
    end
  end

  // FIFO storage; contents are qualified by fifo_vld so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= alu_wr_addr;
      fifo_data[wr_ptr] <= alu_wr_data;
    end
  end

  // Starvation counter: clears on a real MC grant or idle, holds while blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!mc_valid || (grant_mc && !mc_zero)) begin
      starve_cnt <= '0;
    end else if (!grant_mc && !mc_blocked && (starve_cnt < STARVE_C)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Registered write port: load the granted source, hold data when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= grant_fifo || (grant_mc && !mc_zero);
      if (grant_fifo) begin
        rf_wr_addr <= fifo_addr[rd_ptr];
        rf_wr_data <= fifo_data[rd_ptr];
      end else if (grant_mc && !mc_zero) begin
        rf_wr_addr <= mc_addr;
        rf_wr_data <= mc_data;
      end
    end
  end

  // Pending-write mask for the hazard unit: buffered entries plus presented MC.
  always_comb begin
    pend_mask = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (fifo_vld[AW'(i)]) pend_mask[fifo_addr[AW'(i)]] = 1'b1;
      end
      if (mc_valid) pend_mask[mc_addr] = 1'b1;
      pend_mask[0] = 1'b0;
    end
  end

  // Handshake and front-end stall request.
  always_comb begin
    mc_ready  = grant_mc;
    stall_req = !rst && (count >= STALL_LVL);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wr_en;
  logic [4:0]  alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic        mc_valid;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pend_mask;
  logic        stall_req;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];

  regfile_wb_arbiter #(
    .FIFO_DEPTH(4),
    .STALL_THRESH(2),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pend_mask(pend_mask), .stall_req(stall_req), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_wr_en = ae; alu_wr_addr = aa; alu_wr_data = ad;
    mc_valid = mv; mc_addr = ma; mc_data = md;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55);
    tick(); tick();
    checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rf_wr_addr); end
    checks++; if (rf_wr_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", rf_wr_data); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow_err); end
    checks++; if (mc_ready !== 1'b0) begin failures++; $display("FAIL reset_mc_ready got=%0b exp=0", mc_ready); end
    checks++; if (pend_mask !== 32'h0) begin failures++; $display("FAIL reset_pend got=%h exp=0", pend_mask); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL post_reset_en got=%0b exp=0", rf_wr_en); end
  endtask

  task automatic test_alu_latency();
    drive(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (pend_mask !== 32'h0) begin failures++; $display("FAIL alu_pend_pre got=%h exp=0", pend_mask); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (pend_mask !== 32'h20) begin failures++; $display("FAIL alu_pend_mid got=%h exp=20", pend_mask); end
    checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL alu_en_e1 got=%0b exp=0", rf_wr_en); end
    tick();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hAA) begin
      failures++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/aa", rf_wr_en, rf_wr_addr, rf_wr_data); end
    checks++; if (pend_mask !== 32'h0) begin failures++; $display("FAIL alu_pend_post got=%h exp=0", pend_mask); end
    tick();
    checks++; if (rf_wr_en !== 1'b0 || rf_wr_data !== 32'hAA) begin
      failures++; $display("FAIL alu_idle_hold got=%0b/%h exp=0/aa", rf_wr_en, rf_wr_data); end
  endtask

  task automatic test_mc_basic();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    #1;
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL mc_ready got=%0b exp=1", mc_ready); end
    checks++; if (pend_mask !== 32'h80) begin failures++; $display("FAIL mc_pend got=%h exp=80", pend_mask); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h1234) begin
      failures++; $display("FAIL mc_write got=%0b/%0d/%h exp=1/7/1234", rf_wr_en, rf_wr_addr, rf_wr_data); end
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin failures++; $display("FAIL mc_idle got=%0b exp=0", rf_wr_en); end
  endtask

  task automatic test_starve();
    logic [4:0]  ea [5];
    logic [31:0] ed [5];
    logic        er [5];
    ea = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4};
    ed = '{32'h101, 32'h102, 32'h103, 32'h999, 32'h104};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 5'(i + 2), 32'h102 + 32'(i), 1'b1, 5'd9, 32'h999);
      else       drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h999);
      #1;
      checks++; if (mc_ready !== er[i]) begin failures++; $display("FAIL starve_ready[%0d] got=%0b exp=%0b", i, mc_ready, er[i]); end
      if (i == 0) begin
        checks++; if (pend_mask !== 32'h202) begin failures++; $display("FAIL starve_pend got=%h exp=202", pend_mask); end
      end
      tick();
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== ea[i] || rf_wr_data !== ed[i]) begin
        failures++; $display("FAIL starve_grant[%0d] got=%0b/%0d/%h exp=1/%0d/%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, ea[i], ed[i]); end
    end
    // fresh MC request: counter must have cleared, so FIFO wins this cycle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h777);
    #1;
    checks++; if (mc_ready !== 1'b0) begin failures++; $display("FAIL starve_cleared got=%0b exp=0", mc_ready); end
    tick();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== ea[4] || rf_wr_data !== ed[4]) begin
      failures++; $display("FAIL starve_last got=%0b/%0d/%h exp=1/4/104", rf_wr_en, rf_wr_addr, rf_wr_data); end
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL starve_mc2_ready got=%0b exp=1", mc_ready); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_wr_addr !== 5'd20 || rf_wr_data !== 32'h777) begin
      failures++; $display("FAIL starve_mc2 got=%0d/%h exp=20/777", rf_wr_addr, rf_wr_data); end
    tick();
  endtask

  task automatic test_hazard();
    drive(1'b1, 5'd6, 32'h1, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h2);
    #1;
    checks++; if (mc_ready !== 1'b0) begin failures++; $display("FAIL hazard_blocked got=%0b exp=0", mc_ready); end
    checks++; if (pend_mask !== 32'h40) begin failures++; $display("FAIL hazard_pend got=%h exp=40", pend_mask); end
    tick();
    checks++; if (rf_wr_addr !== 5'd6 || rf_wr_data !== 32'h1 || rf_wr_en !== 1'b1) begin
      failures++; $display("FAIL hazard_first got=%0b/%0d/%h exp=1/6/1", rf_wr_en, rf_wr_addr, rf_wr_data); end
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL hazard_release got=%0b exp=1", mc_ready); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_wr_addr !== 5'd6 || rf_wr_data !== 32'h2 || rf_wr_en !== 1'b1) begin
      failures++; $display("FAIL hazard_second got=%0b/%0d/%h exp=1/6/2", rf_wr_en, rf_wr_addr, rf_wr_data); end
    tick();
  endtask

  task automatic test_overflow();
    logic [4:0] order [5];
    order = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd15};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(10 + i), 32'hA00 | 32'(10 + i), 1'b1, 5'd0, 32'h0);
      #1;
      checks++; if (stall_req !== (i >= 2)) begin failures++; $display("FAIL ovf_stall[%0d] got=%0b exp=%0b", i, stall_req, (i >= 2)); end
      checks++; if (mc_ready !== 1'b1 || rf_wr_en !== 1'b0 || overflow_err !== 1'b0) begin
        failures++; $display("FAIL ovf_fill[%0d] got=%0b/%0b/%0b exp=1/0/0", i, mc_ready, rf_wr_en, overflow_err); end
      tick();
    end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow_err); end
    drive(1'b1, 5'd15, 32'hA0F, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (pend_mask !== 32'h3C00) begin failures++; $display("FAIL ovf_pend_full got=%h exp=3c00", pend_mask); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (pend_mask !== 32'hB800) begin failures++; $display("FAIL ovf_pend_swap got=%h exp=b800", pend_mask); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== order[i] || rf_wr_data !== (32'hA00 | 32'(order[i]))) begin
        failures++; $display("FAIL ovf_drain[%0d] got=%0b/%0d/%h exp=1/%0d", i, rf_wr_en, rf_wr_addr, rf_wr_data, order[i]); end
      tick();
    end
    checks++; if (rf_wr_en !== 1'b0 || overflow_err !== 1'b1 || stall_req !== 1'b0) begin
      failures++; $display("FAIL ovf_end got=%0b/%0b/%0b exp=0/1/0", rf_wr_en, overflow_err, stall_req); end
  endtask

  task automatic test_x0_reset();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    #1;
    checks++; if (mc_ready !== 1'b1 || pend_mask !== 32'h0) begin
      failures++; $display("FAIL x0_accept got=%0b/%h exp=1/0", mc_ready, pend_mask); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (rf_wr_en !== 1'b0 || pend_mask !== 32'h0 || stall_req !== 1'b0) begin
      failures++; $display("FAIL x0_nowrite got=%0b/%h/%0b exp=0/0/0", rf_wr_en, pend_mask, stall_req); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'hD0 + 32'(i), 1'b1, 5'd0, 32'h0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd1 || pend_mask !== 32'h1C || stall_req !== 1'b1) begin
      failures++; $display("FAIL rst_pre got=%0b/%0d/%h/%0b exp=1/1/1c/1", rf_wr_en, rf_wr_addr, pend_mask, stall_req); end
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777);
    #1;
    checks++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'h0 || overflow_err !== 1'b0) begin
      failures++; $display("FAIL rst_async got=%0b/%0d/%h/%0b exp=0/0/0/0", rf_wr_en, rf_wr_addr, rf_wr_data, overflow_err); end
    checks++; if (mc_ready !== 1'b0 || pend_mask !== 32'h0 || stall_req !== 1'b0) begin
      failures++; $display("FAIL rst_comb got=%0b/%h/%0b exp=0/0/0", mc_ready, pend_mask, stall_req); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mc_ready !== 1'b1 || pend_mask !== 32'h80 || stall_req !== 1'b0) begin
      failures++; $display("FAIL rst_after got=%0b/%h/%0b exp=1/80/0", mc_ready, pend_mask, stall_req); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h7777) begin
      failures++; $display("FAIL rst_mc_repr got=%0b/%0d/%h exp=1/7/7777", rf_wr_en, rf_wr_addr, rf_wr_data); end
    tick();
    checks++; if (rf_wr_en !== 1'b0 || pend_mask !== 32'h0) begin
      failures++; $display("FAIL rst_discard got=%0b/%h exp=0/0", rf_wr_en, pend_mask); end
  endtask

  task automatic test_random();
    logic        a_en, m_v, m_pend, blk, gmc, gf, e_en, e_ovf;
    logic [4:0]  a_ad, m_a, e_addr;
    logic [31:0] a_d, m_d, e_data, e_pm;
    int          starve;
    m_pend = 1'b0; m_v = 1'b0; m_a = '0; m_d = '0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 400 == 0) begin
        // asynchronous reset pulse between edges; held MC result stays presented
        rst = 1'b1;
        alu_wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        starve = 0; e_en = 1'b0; e_addr = '0; e_data = '0; e_ovf = 1'b0;
      end
      a_en = ($urandom_range(0, 3) != 0);
      a_ad = 5'($urandom_range(0, 7));
      a_d  = $urandom();
      if (!m_pend) begin
        m_v = ($urandom_range(0, 2) == 0);
        m_a = 5'($urandom_range(0, 7));
        m_d = $urandom();
      end
      drive(a_en, a_ad, a_d, m_v, m_a, m_d);
      #1;
      blk = 1'b0; e_pm = '0;
      foreach (mq[k]) begin
        e_pm[mq[k].a] = 1'b1;
        if (m_v && (mq[k].a == m_a)) blk = 1'b1;
      end
      if (m_v) e_pm[m_a] = 1'b1;
      e_pm[0] = 1'b0;
      gmc = m_v && !blk && ((mq.size() == 0) || (starve >= 3) || (m_a == 5'd0));
      gf  = (mq.size() != 0) && !gmc;
      checks++; if (mc_ready !== gmc) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, mc_ready, gmc); end
      checks++; if (pend_mask !== e_pm) begin failures++; $display("FAIL rnd_pend n=%0d got=%h exp=%h", n, pend_mask, e_pm); end
      checks++; if (stall_req !== (mq.size() >= 2)) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall_req, (mq.size() >= 2)); end
      checks++; if (rf_wr_en !== e_en || rf_wr_addr !== e_addr || rf_wr_data !== e_data) begin
        failures++; $display("FAIL rnd_rf n=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", n, rf_wr_en, rf_wr_addr, rf_wr_data, e_en, e_addr, e_data); end
      checks++; if (overflow_err !== e_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, overflow_err, e_ovf); end
      // reference update for the coming edge
      if (gmc && (m_a != 5'd0)) begin
        e_en = 1'b1; e_addr = m_a; e_data = m_d;
      end else if (gf) begin
        e_en = 1'b1; e_addr = mq[0].a; e_data = mq[0].d;
      end else begin
        e_en = 1'b0;
      end
      if (!m_v) starve = 0;
      else if (gmc) begin if (m_a != 5'd0) starve = 0; end
      else if (!blk) starve = (starve < 3) ? starve + 1 : 3;
      if (a_en && (a_ad != 5'd0)) begin
        if ((mq.size() == 4) && !gf) e_ovf = 1'b1;
        else mq.push_back('{a: a_ad, d: a_d});
      end
      if (gf) void'(mq.pop_front());
      m_pend = m_v && !gmc;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_alu_latency();
    test_mc_basic();
    test_starve();
    test_hazard();
    test_overflow();
    test_x0_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
